// File: rtl/prim_secded_inv_22_16_pkg.sv
// Shared definitions for the inverted Hsiao SECDED(22,16) code: inversion
// constant, parity-check row masks, error classification and syndrome helper.
package prim_secded_inv_22_16_pkg;

    // Bits of the stored codeword that are inverted relative to the plain code.
    localparam logic [21:0] INV_CONST = 22'h2a0000;

    // Parity-check rows; ROW_MASK[i] selects the codeword bits feeding syndrome bit i.
    localparam logic [5:0][21:0] ROW_MASK = {
        22'h2011f3, 22'h10aca5, 22'h087714,
        22'h048ed8, 22'h02f20b, 22'h01496e
    };

    typedef enum logic [1:0] {
        ERR_NONE   = 2'b00,
        ERR_SINGLE = 2'b01,
        ERR_DOUBLE = 2'b10
    } err_e;

    // Syndrome of an already de-inverted codeword.
    function automatic logic [5:0] calc_syndrome(input logic [21:0] word);
        logic [5:0] syn;
        syn = '0;
        for (int i = 0; i < 6; i++) begin
            syn[i] = ^(word & ROW_MASK[i]);
        end
        return syn;
    endfunction

endpackage

// File: rtl/prim_secded_inv_22_16_dec_pipe_if.sv
// Codeword-in / result-out handshake bundle of the pipelined SECDED decoder.
// The decoder uses the slave view, its driver/consumer the master view.
interface prim_secded_inv_22_16_dec_pipe_if;

    logic        in_valid_i;
    logic        in_ready_o;
    logic [21:0] in_data_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [15:0] out_data_o;
    logic [5:0]  out_syndrome_o;
    logic [1:0]  out_err_o;

    modport slave (
        input  in_valid_i, in_data_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o, out_syndrome_o, out_err_o
    );

    modport master (
        output in_valid_i, in_data_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o, out_syndrome_o, out_err_o
    );

endinterface

// File: rtl/prim_secded_inv_22_16_dec_core.sv
// Combinational SECDED(22,16) correction: given data bits and syndrome,
// returns corrected data and the error class. Shared with the scrubber.
module prim_secded_inv_22_16_dec_core
    import prim_secded_inv_22_16_pkg::*;
(
    input  logic [15:0] data_i,
    input  logic [5:0]  syndrome_i,
    output logic [15:0] data_o,
    output err_e        err_o
);

    // Flip the data bit whose H column equals the syndrome; classify by syndrome weight parity.
    always_comb begin
        logic [5:0] col;
        col    = '0;
        data_o = data_i;
        for (int j = 0; j < 16; j++) begin
            for (int i = 0; i < 6; i++) begin
                col[i] = ROW_MASK[i][j];
            end
            if (syndrome_i == col) begin
                data_o[j] = ~data_i[j];
            end
        end
        if (syndrome_i == 6'h00) begin
            err_o = ERR_NONE;
        end else if (^syndrome_i) begin
            err_o = ERR_SINGLE;
        end else begin
            err_o = ERR_DOUBLE;
        end
    end

endmodule

// File: rtl/prim_secded_inv_22_16_dec_pipe.sv
// Two-stage elastic decoder for inverted SECDED(22,16) codewords with
// optional error statistics. Statistics and first-double-error capture are
// built only when PRIM_SECDED_DEC_ERR_CNT_EN is defined; otherwise those
// outputs are tied to zero and cnt_clr_i is ignored.
module prim_secded_inv_22_16_dec_pipe
    import prim_secded_inv_22_16_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    prim_secded_inv_22_16_dec_pipe_if.slave bus,
    input  logic                 cnt_clr_i,
    output logic [CNT_W-1:0]     sec_cnt_o,
    output logic [CNT_W-1:0]     ded_cnt_o,
    output logic                 ded_seen_o,
    output logic [21:0]          ded_word_o
);

    logic        s1_valid_q, s1_valid_d;
    logic [15:0] s1_data_q, s1_data_d;
    logic [5:0]  s1_syn_q, s1_syn_d;
    logic [21:0] s1_raw_q, s1_raw_d;

    logic        s2_valid_q, s2_valid_d;
    logic [15:0] s2_data_q, s2_data_d;
    logic [5:0]  s2_syn_q, s2_syn_d;
    err_e        s2_err_q, s2_err_d;
    logic [21:0] s2_raw_q, s2_raw_d;

    logic        s2_ready;
    logic        in_ready;
    logic        out_fire;
    logic [21:0] in_word;
    logic [15:0] core_data;
    err_e        core_err;

    assign s2_ready = !s2_valid_q || bus.out_ready_i;
    assign in_ready = !s1_valid_q || s2_ready;
    assign out_fire = s2_valid_q && bus.out_ready_i;
    assign in_word  = bus.in_data_i ^ INV_CONST;

    assign bus.in_ready_o     = in_ready;
    assign bus.out_valid_o    = s2_valid_q;
    assign bus.out_data_o     = s2_data_q;
    assign bus.out_syndrome_o = s2_syn_q;
    assign bus.out_err_o      = s2_err_q;

    prim_secded_inv_22_16_dec_core u_core (
        .data_i     (s1_data_q),
        .syndrome_i (s1_syn_q),
        .data_o     (core_data),
        .err_o      (core_err)
    );

    // Stage 1 takes a new codeword whenever it is empty or stage 2 drains it this cycle.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_syn_d   = s1_syn_q;
        s1_raw_d   = s1_raw_q;
        if (in_ready) begin
            s1_valid_d = bus.in_valid_i;
            if (bus.in_valid_i) begin
                s1_data_d = in_word[15:0];
                s1_syn_d  = calc_syndrome(in_word);
                s1_raw_d  = bus.in_data_i;
            end
        end
    end

    // Stage 2 captures the corrected result; it only changes when the consumer can see a new word.
    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_syn_d   = s2_syn_q;
        s2_err_d   = s2_err_q;
        s2_raw_d   = s2_raw_q;
        if (s2_ready) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d = core_data;
                s2_syn_d  = s1_syn_q;
                s2_err_d  = core_err;
                s2_raw_d  = s1_raw_q;
            end
        end
    end

    // Pipeline registers; reset discards any in-flight words.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_syn_q   <= '0;
            s1_raw_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_syn_q   <= '0;
            s2_err_q   <= ERR_NONE;
            s2_raw_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_syn_q   <= s1_syn_d;
            s1_raw_q   <= s1_raw_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_syn_q   <= s2_syn_d;
            s2_err_q   <= s2_err_d;
            s2_raw_q   <= s2_raw_d;
        end
    end

`ifdef PRIM_SECDED_DEC_ERR_CNT_EN
    logic [CNT_W-1:0] sec_cnt_q, sec_cnt_d;
    logic [CNT_W-1:0] ded_cnt_q, ded_cnt_d;
    logic             ded_seen_q, ded_seen_d;
    logic [21:0]      ded_word_q, ded_word_d;

    // Count delivered errors with saturation and latch the first double error; clear has priority.
    always_comb begin
        sec_cnt_d  = sec_cnt_q;
        ded_cnt_d  = ded_cnt_q;
        ded_seen_d = ded_seen_q;
        ded_word_d = ded_word_q;
        if (cnt_clr_i) begin
            sec_cnt_d  = '0;
            ded_cnt_d  = '0;
            ded_seen_d = 1'b0;
            ded_word_d = '0;
        end else if (out_fire) begin
            if (s2_err_q == ERR_SINGLE && sec_cnt_q != {CNT_W{1'b1}}) begin
                sec_cnt_d = sec_cnt_q + CNT_W'(1);
            end
            if (s2_err_q == ERR_DOUBLE) begin
                if (ded_cnt_q != {CNT_W{1'b1}}) begin
                    ded_cnt_d = ded_cnt_q + CNT_W'(1);
                end
                if (!ded_seen_q) begin
                    ded_seen_d = 1'b1;
                    ded_word_d = s2_raw_q;
                end
            end
        end
    end

    // Statistics registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sec_cnt_q  <= '0;
            ded_cnt_q  <= '0;
            ded_seen_q <= 1'b0;
            ded_word_q <= '0;
        end else begin
            sec_cnt_q  <= sec_cnt_d;
            ded_cnt_q  <= ded_cnt_d;
            ded_seen_q <= ded_seen_d;
            ded_word_q <= ded_word_d;
        end
    end

    assign sec_cnt_o  = sec_cnt_q;
    assign ded_cnt_o  = ded_cnt_q;
    assign ded_seen_o = ded_seen_q;
    assign ded_word_o = ded_word_q;
`else
    logic unused_stats;
    assign unused_stats = ^{cnt_clr_i, out_fire, s2_raw_q};

    assign sec_cnt_o  = '0;
    assign ded_cnt_o  = '0;
    assign ded_seen_o = 1'b0;
    assign ded_word_o = '0;
`endif

endmodule

// File: tb/tb_prim_secded_inv_22_16_dec_pipe.sv
// Self-checking bench for the pipelined SECDED(22,16) decoder: directed
// test-plan words, a scoreboard fed from an independent reference model,
// backpressure/hold checks and mid-stream reset.
`timescale 1ns/1ps
module tb_prim_secded_inv_22_16_dec_pipe;

    localparam int CNT_W = 16;
`ifdef PRIM_SECDED_DEC_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    localparam logic [21:0] M_ROW [6] = '{22'h01496e, 22'h02f20b, 22'h048ed8,
                                          22'h087714, 22'h10aca5, 22'h2011f3};

    typedef struct packed {
        logic [15:0] data;
        logic [5:0]  syn;
        logic [1:0]  err;
        logic [21:0] raw;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             cnt_clr;
    logic [CNT_W-1:0] sec_cnt;
    logic [CNT_W-1:0] ded_cnt;
    logic             ded_seen;
    logic [21:0]      ded_word;

    prim_secded_inv_22_16_dec_pipe_if dec_if ();

    prim_secded_inv_22_16_dec_pipe #(.CNT_W(CNT_W)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .bus        (dec_if),
        .cnt_clr_i  (cnt_clr),
        .sec_cnt_o  (sec_cnt),
        .ded_cnt_o  (ded_cnt),
        .ded_seen_o (ded_seen),
        .ded_word_o (ded_word)
    );

    always #5 clk = ~clk;

    int               errors = 0;
    int               checks = 0;
    int               accepted = 0;
    exp_t             sb_q[$];
    logic [CNT_W-1:0] m_sec = '0;
    logic [CNT_W-1:0] m_ded = '0;
    logic             m_seen = 1'b0;
    logic [21:0]      m_word = '0;

    // Syndrome built column by column from the set bits of the word.
    function automatic logic [5:0] model_syn(input logic [21:0] w);
        logic [5:0] s;
        s = '0;
        for (int b = 0; b < 22; b++) begin
            if (w[b]) begin
                for (int i = 0; i < 6; i++) begin
                    s[i] = s[i] ^ M_ROW[i][b];
                end
            end
        end
        return s;
    endfunction

    // Reference decode: correct by searching for the single data-bit flip that zeroes the syndrome.
    function automatic exp_t model_decode(input logic [21:0] raw);
        exp_t        e;
        logic [21:0] w;
        logic [5:0]  s;
        w      = raw ^ 22'h2a0000;
        s      = model_syn(w);
        e.raw  = raw;
        e.syn  = s;
        e.data = w[15:0];
        if (s == 6'h00) begin
            e.err = 2'b00;
        end else if (($countones(s) % 2) == 1) begin
            e.err = 2'b01;
            for (int j = 0; j < 16; j++) begin
                if (model_syn(w ^ (22'h1 << j)) == 6'h00) begin
                    e.data[j] = ~w[j];
                end
            end
        end else begin
            e.err = 2'b10;
        end
        return e;
    endfunction

    // Monitor at the falling edge: scoreboard push/pop, output hold check and statistics model.
    initial begin
        exp_t        e;
        logic        stall_prev;
        logic [23:0] held;
        stall_prev = 1'b0;
        held       = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev && dec_if.out_valid_o) begin
                    checks++;
                    if ({dec_if.out_data_o, dec_if.out_syndrome_o, dec_if.out_err_o} !== held) begin
                        errors++;
                        $display("[TB] FAIL hold_stable: got %h want %h", {dec_if.out_data_o, dec_if.out_syndrome_o, dec_if.out_err_o}, held);
                    end
                end
                if (dec_if.out_valid_o && dec_if.out_ready_i) begin
                    checks++;
                    if (sb_q.size() == 0) begin
                        errors++;
                        $display("[TB] FAIL unexpected_output: data %h with empty scoreboard", dec_if.out_data_o);
                    end else begin
                        e = sb_q.pop_front();
                        if ({dec_if.out_data_o, dec_if.out_syndrome_o, dec_if.out_err_o} !== {e.data, e.syn, e.err}) begin
                            errors++;
                            $display("[TB] FAIL scoreboard raw=%h: got data=%h syn=%h err=%b want data=%h syn=%h err=%b",
                                     e.raw, dec_if.out_data_o, dec_if.out_syndrome_o, dec_if.out_err_o, e.data, e.syn, e.err);
                        end
                        if (CNT_EN) begin
                            if (e.err == 2'b01 && m_sec != {CNT_W{1'b1}}) m_sec = m_sec + 1'b1;
                            if (e.err == 2'b10) begin
                                if (m_ded != {CNT_W{1'b1}}) m_ded = m_ded + 1'b1;
                                if (!m_seen) begin
                                    m_seen = 1'b1;
                                    m_word = e.raw;
                                end
                            end
                        end
                    end
                end
                if (cnt_clr) begin
                    m_sec  = '0;
                    m_ded  = '0;
                    m_seen = 1'b0;
                    m_word = '0;
                end
                stall_prev = dec_if.out_valid_o && !dec_if.out_ready_i;
                held       = {dec_if.out_data_o, dec_if.out_syndrome_o, dec_if.out_err_o};
                if (dec_if.in_valid_i && dec_if.in_ready_o) begin
                    sb_q.push_back(model_decode(dec_if.in_data_i));
                    accepted++;
                end
            end
        end
    end

    // Present one codeword and hold it until accepted; returns cycles spent.
    task automatic send_word(input logic [21:0] raw, output int cycles);
        logic acc;
        acc    = 1'b0;
        cycles = 0;
        dec_if.in_valid_i = 1'b1;
        dec_if.in_data_i  = raw;
        while (!acc && cycles < 200) begin
            @(negedge clk);
            acc = dec_if.in_ready_o;
            @(posedge clk);
            #1;
            cycles++;
        end
        dec_if.in_valid_i = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("[TB] FAIL send_timeout: word %h not accepted, in_ready=%b want 1", raw, dec_if.in_ready_o);
        end
    endtask

    // Wait until out_valid_o is seen; returns cycles waited after the accepting edge.
    task automatic wait_output(output int cycles);
        cycles = 0;
        while (!dec_if.out_valid_o && cycles < 20) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    // Wait until every accepted word has been delivered and the pipe is idle.
    task automatic drain();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || dec_if.out_valid_o) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (sb_q.size() != 0 || dec_if.out_valid_o) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout: pending=%0d out_valid=%b want 0/0", sb_q.size(), dec_if.out_valid_o);
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({dec_if.out_valid_o, dec_if.out_data_o, dec_if.out_syndrome_o, dec_if.out_err_o} !== 25'h0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got valid=%b data=%h syn=%h err=%b want all 0",
                     dec_if.out_valid_o, dec_if.out_data_o, dec_if.out_syndrome_o, dec_if.out_err_o);
        end
        checks++;
        if ({sec_cnt, ded_cnt, ded_seen, ded_word} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_stats: got sec=%0d ded=%0d seen=%b word=%h want 0", sec_cnt, ded_cnt, ded_seen, ded_word);
        end
    endtask

    // Send one word with a free consumer, check latency and the decoded fields.
    task automatic test_single_word(input string name, input logic [21:0] raw, input logic [15:0] exp_data,
                                    input logic [5:0] exp_syn, input logic [1:0] exp_err);
        int c;
        int lat;
        dec_if.out_ready_i = 1'b1;
        send_word(raw, c);
        wait_output(lat);
        checks++;
        if (lat != 1) begin
            errors++;
            $display("[TB] FAIL %s_latency: got %0d cycles want 2", name, lat + 1);
        end
        checks++;
        if ({dec_if.out_data_o, dec_if.out_syndrome_o, dec_if.out_err_o} !== {exp_data, exp_syn, exp_err}) begin
            errors++;
            $display("[TB] FAIL %s_fields: got data=%h syn=%h err=%b want data=%h syn=%h err=%b",
                     name, dec_if.out_data_o, dec_if.out_syndrome_o, dec_if.out_err_o, exp_data, exp_syn, exp_err);
        end
        drain();
    endtask

    task automatic test_plan_words();
        test_single_word("clean", 22'h2a0000, 16'h0000, 6'h00, 2'b00);
        checks++;
        if (sec_cnt !== '0 || ded_cnt !== '0) begin
            errors++;
            $display("[TB] FAIL clean_counters: got sec=%0d ded=%0d want 0/0", sec_cnt, ded_cnt);
        end
        test_single_word("data_flip", 22'h2a0001, 16'h0000, 6'h32, 2'b01);
        checks++;
        if (sec_cnt !== (CNT_EN ? 16'd1 : 16'd0)) begin
            errors++;
            $display("[TB] FAIL data_flip_sec_cnt: got %0d want %0d", sec_cnt, CNT_EN ? 1 : 0);
        end
        test_single_word("check_flip", 22'h2b0000, 16'h0000, 6'h01, 2'b01);
        test_single_word("all_zero", 22'h000000, 16'h1000, 6'h2a, 2'b01);
        checks++;
        if (sec_cnt !== (CNT_EN ? 16'd3 : 16'd0)) begin
            errors++;
            $display("[TB] FAIL single_total_sec_cnt: got %0d want %0d", sec_cnt, CNT_EN ? 3 : 0);
        end
    endtask

    task automatic test_double_and_clear();
        test_single_word("double1", 22'h2a0003, 16'h0003, 6'h11, 2'b10);
        checks++;
        if ({ded_cnt, ded_seen, ded_word} !== (CNT_EN ? {16'd1, 1'b1, 22'h2a0003} : 39'h0)) begin
            errors++;
            $display("[TB] FAIL double_capture: got ded=%0d seen=%b word=%h", ded_cnt, ded_seen, ded_word);
        end
        test_single_word("double2", 22'h2a0005, 16'h0005, 6'h2b, 2'b10);
        checks++;
        if ({ded_cnt, ded_seen, ded_word} !== (CNT_EN ? {16'd2, 1'b1, 22'h2a0003} : 39'h0)) begin
            errors++;
            $display("[TB] FAIL double_no_overwrite: got ded=%0d seen=%b word=%h", ded_cnt, ded_seen, ded_word);
        end
        @(posedge clk);
        #1;
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        checks++;
        if ({sec_cnt, ded_cnt, ded_seen, ded_word} !== '0) begin
            errors++;
            $display("[TB] FAIL clear_stats: got sec=%0d ded=%0d seen=%b word=%h want 0", sec_cnt, ded_cnt, ded_seen, ded_word);
        end
    endtask

    // Consecutive random words with a free consumer: one accept per cycle, model-checked outputs.
    task automatic test_back_to_back();
        int c;
        int total;
        total = 0;
        dec_if.out_ready_i = 1'b1;
        for (int k = 0; k < 12; k++) begin
            send_word(22'($urandom()), c);
            total += c;
        end
        checks++;
        if (total != 12) begin
            errors++;
            $display("[TB] FAIL b2b_throughput: got %0d cycles want 12", total);
        end
        drain();
        checks++;
        if ({sec_cnt, ded_cnt, ded_seen, ded_word} !== {m_sec, m_ded, m_seen, m_word}) begin
            errors++;
            $display("[TB] FAIL b2b_stats: got sec=%0d ded=%0d seen=%b word=%h want sec=%0d ded=%0d seen=%b word=%h",
                     sec_cnt, ded_cnt, ded_seen, ded_word, m_sec, m_ded, m_seen, m_word);
        end
    endtask

    task automatic test_backpressure();
        int acc0;
        logic [21:0] words [4];
        words[0] = 22'h2a0001;
        words[1] = 22'h2a1234;
        words[2] = 22'h2a0003;
        words[3] = 22'h15abcd;
        acc0 = accepted;
        dec_if.out_ready_i = 1'b0;
        fork
            begin
                int c;
                for (int k = 0; k < 4; k++) begin
                    send_word(words[k], c);
                end
            end
            begin
                repeat (6) begin
                    @(posedge clk);
                    #1;
                end
                checks++;
                if (accepted - acc0 != 2 || dec_if.in_ready_o !== 1'b0 || dec_if.out_valid_o !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL bp_stall: got accepted=%0d in_ready=%b out_valid=%b want 2/0/1",
                             accepted - acc0, dec_if.in_ready_o, dec_if.out_valid_o);
                end
                dec_if.out_ready_i = 1'b1;
            end
        join
        drain();
        checks++;
        if (accepted - acc0 != 4) begin
            errors++;
            $display("[TB] FAIL bp_accept_count: got %0d want 4", accepted - acc0);
        end
    endtask

    task automatic test_reset_mid();
        int c;
        test_single_word("pre_reset", 22'h2a0001, 16'h0000, 6'h32, 2'b01);
        dec_if.out_ready_i = 1'b0;
        send_word(22'h2a00ff, c);
        send_word(22'h2a0f0f, c);
        checks++;
        if (dec_if.out_valid_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_fill: got out_valid=%b want 1", dec_if.out_valid_o);
        end
        rst = 1'b1;
        #1;
        sb_q.delete();
        m_sec  = '0;
        m_ded  = '0;
        m_seen = 1'b0;
        m_word = '0;
        checks++;
        if (dec_if.out_valid_o !== 1'b0 || dec_if.in_ready_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_reset_valid: got out_valid=%b in_ready=%b want 0/1", dec_if.out_valid_o, dec_if.in_ready_o);
        end
        checks++;
        if ({sec_cnt, ded_cnt, ded_seen, ded_word} !== '0) begin
            errors++;
            $display("[TB] FAIL mid_reset_stats: got sec=%0d ded=%0d seen=%b word=%h want 0", sec_cnt, ded_cnt, ded_seen, ded_word);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        dec_if.out_ready_i = 1'b1;
        test_single_word("post_reset", 22'h2b0000, 16'h0000, 6'h01, 2'b01);
    endtask

    initial begin
        rst                = 1'b1;
        cnt_clr            = 1'b0;
        dec_if.in_valid_i  = 1'b0;
        dec_if.in_data_i   = '0;
        dec_if.out_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        @(posedge clk);
        #1;
        test_plan_words();
        test_double_and_clear();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
